// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator: internal width rule, order limit
// and the decimation-ratio clamp.
package cic_pkg;

  localparam int ORDER_MAX = 6;

  // Register growth: ORDER stages each gaining at most RLOG2_MAX bits.
  function automatic int cic_bw(input int dw, input int order, input int rlog2_max);
    return dw + order * rlog2_max;
  endfunction

  function automatic int cic_order(input int order);
    if (order < 1)
      return 1;
    else if (order > ORDER_MAX)
      return ORDER_MAX;
    else
      return order;
  endfunction

  function automatic int clamp_os(input int os, input int rlog2_max);
    return (os > rlog2_max) ? rlog2_max : os;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb stage: registered first difference (M=1) advanced only on enable.
module cic_comb_stage #(
  parameter int BW = 28
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [BW-1:0] sample,
  output logic signed [BW-1:0] diff
);

  logic signed [BW-1:0] delayed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      delayed <= '0;
      diff    <= '0;
    end else if (clear) begin
      delayed <= '0;
      diff    <= '0;
    end else if (en) begin
      diff    <= sample - delayed;
      delayed <= sample;
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// CIC decimator, R = 2**os_sel, gain-normalised output.
// Define CIC_ROUND_SAT_EN for round-half-up and saturation; otherwise truncating shift.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int DW        = 16,
  parameter int ORDER     = 3,
  parameter int RLOG2_MAX = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [$clog2(RLOG2_MAX+1)-1:0]   os_sel,
  input  logic                             in_valid,
  input  logic signed [DW-1:0]             data_in,
  output logic                             out_valid,
  output logic signed [DW-1:0]             data_out
);

  localparam int N   = cic_order(ORDER);
  localparam int BW  = cic_bw(DW, N, RLOG2_MAX);
  localparam int SW  = $clog2(RLOG2_MAX + 1);
  localparam int CW  = (RLOG2_MAX < 1) ? 1 : RLOG2_MAX;
  localparam int SHW = (N * RLOG2_MAX < 1) ? 1 : $clog2(N * RLOG2_MAX + 1);

  logic [SW-1:0]        os_eff;
  logic [SW-1:0]        os_prev;
  logic                 os_known;
  logic                 clear;
  logic                 accept;
  logic                 strobe;
  logic [CW-1:0]        phase;
  logic [CW-1:0]        last_phase;
  logic [SHW-1:0]       shamt;
  logic [N-1:0]         vpipe;
  logic signed [BW-1:0] din_ext;
  logic signed [BW-1:0] comb_last;
  logic signed [DW-1:0] data_next;

  assign os_eff     = SW'(clamp_os(int'(os_sel), RLOG2_MAX));
  assign last_phase = CW'((1 << os_eff) - 1);
  assign shamt      = SHW'(N * int'(os_eff));
  assign din_ext    = {{(BW-DW){data_in[DW-1]}}, data_in};

  // os_known keeps the first cycle after reset from looking like a ratio change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_prev  <= '0;
      os_known <= 1'b0;
    end else begin
      os_prev  <= os_sel;
      os_known <= 1'b1;
    end
  end

  assign clear  = os_known && (os_sel != os_prev);
  assign accept = in_valid && !clear;
  assign strobe = accept && (phase == last_phase);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      phase <= '0;
    else if (clear)
      phase <= '0;
    else if (accept)
      phase <= strobe ? '0 : phase + CW'(1);
  end

  // Integrators chain combinationally so the strobe sample is already included
  // in the value handed to the first comb.
  for (genvar k = 0; k < N; k++) begin : g_int
    logic signed [BW-1:0] acc;
    logic signed [BW-1:0] acc_nxt;

    if (k == 0) begin : g_head
      assign acc_nxt = acc + din_ext;
    end else begin : g_tail
      assign acc_nxt = acc + g_int[k-1].acc_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
        acc <= '0;
      else if (clear)
        acc <= '0;
      else if (accept)
        acc <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      vpipe <= '0;
    else if (clear)
      vpipe <= '0;
    else
      vpipe <= (vpipe << 1) | N'(strobe);
  end

  for (genvar k = 0; k < N; k++) begin : g_comb
    logic signed [BW-1:0] sample;
    logic signed [BW-1:0] diff;
    logic                 en;

    if (k == 0) begin : g_head
      assign sample = g_int[N-1].acc_nxt;
      assign en     = strobe;
    end else begin : g_tail
      assign sample = g_comb[k-1].diff;
      assign en     = vpipe[k-1];
    end

    cic_comb_stage #(.BW(BW)) u_stage (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (clear),
      .en      (en),
      .sample  (sample),
      .diff    (diff)
    );
  end

  assign comb_last = g_comb[N-1].diff;

`ifdef CIC_ROUND_SAT_EN
  localparam logic signed [BW:0] SAT_HI = {{(BW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [BW:0] SAT_LO = ~SAT_HI;

  logic        [BW:0] bias;
  logic signed [BW:0] biased;
  logic signed [BW:0] scaled;

  // One extra bit so the rounding bias can never wrap the comb result.
  always_comb begin
    bias   = ((BW+1)'(1) << shamt) >> 1;
    biased = {comb_last[BW-1], comb_last} + $signed(bias);
    scaled = biased >>> shamt;
    if (scaled > SAT_HI)
      data_next = SAT_HI[DW-1:0];
    else if (scaled < SAT_LO)
      data_next = SAT_LO[DW-1:0];
    else
      data_next = scaled[DW-1:0];
  end
`else
  assign data_next = DW'(comb_last >>> shamt);
`endif

  // data_out is only loaded on a pulse, so it holds between pulses and across clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      out_valid <= vpipe[N-1] && !clear;
      if (vpipe[N-1] && !clear)
        data_out <= data_next;
    end
  end

endmodule
